// File: rtl/neuron_pkg.sv
// Shared types and helpers for the fixed-point neuron MAC core.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} neuron_state_e;

  localparam int WIDE_BITS = 64;

  // Accumulator width that cannot overflow for num_weights full-scale products.
  function automatic int acc_bits(input int data_bits, input int num_weights);
    return 2 * data_bits + $clog2(num_weights);
  endfunction

  function automatic logic signed [WIDE_BITS-1:0] sat_to_data(
    input logic signed [WIDE_BITS-1:0] v,
    input int                          data_bits
  );
    logic signed [WIDE_BITS-1:0] hi;
    logic signed [WIDE_BITS-1:0] lo;
    hi = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/neuron_mac_core_weight_ram.sv
// Single-port-write weight RAM with a registered read port and write-to-read forwarding.
module neuron_weight_ram #(
  parameter int DATA_BITS   = 16,
  parameter int NUM_WEIGHTS = 784,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [NUM_WEIGHTS];
  logic                 wr_in_range;

  assign wr_in_range = {1'b0, wr_addr} < (ADDR_BITS + 1)'(NUM_WEIGHTS);

  // NOTE: storage arrays get no reset; contents survive rst and only the control path restarts.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr] <= wr_data;
    // Forward a same-cycle write so the next beat sees the freshly loaded weight.
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/neuron_mac_core.sv
// Fixed-point neuron: weight RAM, MAC pipeline, bias, saturation and activation.
// Build option: define NEURON_RELU_EN for ReLU activation; otherwise linear.
module neuron_mac_core
  import neuron_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_WEIGHTS = 784,
  parameter int ADDR_BITS   = 10,
  parameter int LAYER_NO    = 0,
  parameter int NEURON_NO   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wt_wr_en,
  input  logic [ADDR_BITS-1:0] wt_wr_addr,
  input  logic [DATA_BITS-1:0] wt_wr_data,
  input  logic                 bias_wr_en,
  input  logic [DATA_BITS-1:0] bias_wr_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int                   ACC_W    = acc_bits(DATA_BITS, NUM_WEIGHTS);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_WEIGHTS - 1);

  neuron_state_e                 state;
  logic [ADDR_BITS-1:0]          count;
  logic [ADDR_BITS-1:0]          rd_addr;
  logic                          drain_cnt;
  logic [DATA_BITS-1:0]          w_rd;
  logic signed [DATA_BITS-1:0]   bias;
  logic signed [2*DATA_BITS-1:0] prod;
  logic                          prod_valid;
  logic signed [ACC_W-1:0]       acc;
  logic                          beat;
  logic                          last_beat;
  logic signed [WIDE_BITS-1:0]   res_wide;
  logic signed [DATA_BITS-1:0]   res_sat;
  logic signed [DATA_BITS-1:0]   act;

  assign beat      = in_valid && in_ready;
  assign last_beat = (count == LAST_IDX);

  // Read address runs one ahead of count so w[count] is registered by the time its beat arrives.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_addr = count;
    if (state != IDLE && state != ACCUM) rd_addr = '0;
    else if (beat)                       rd_addr = last_beat ? '0 : count + ADDR_BITS'(1);
  end

  neuron_weight_ram #(
    .DATA_BITS  (DATA_BITS),
    .NUM_WEIGHTS(NUM_WEIGHTS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_weight_ram (
    .clk    (clk),
    .wr_en  (wt_wr_en && (state == IDLE)),
    .wr_addr(wt_wr_addr),
    .wr_data(wt_wr_data),
    .rd_addr(rd_addr),
    .rd_data(w_rd)
  );

  assign res_wide = WIDE_BITS'(acc >>> FRAC_BITS) + WIDE_BITS'(bias);
  assign res_sat  = DATA_BITS'(sat_to_data(res_wide, DATA_BITS));

`ifdef NEURON_RELU_EN
  assign act = res_sat[DATA_BITS-1] ? '0 : res_sat;
`else
  assign act = res_sat;
`endif

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      drain_cnt  <= 1'b0;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      bias       <= '0;
    end else begin
      prod_valid <= beat;
      if (beat) prod <= (2*DATA_BITS)'($signed(w_rd)) * (2*DATA_BITS)'($signed(in_data));
      if (prod_valid) acc <= acc + ACC_W'(prod);
      if (beat && (last_beat != in_last)) frame_err <= 1'b1;

      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (state == IDLE && bias_wr_en) bias <= $signed(bias_wr_data);
          if (beat) begin
            busy <= 1'b1;
            if (last_beat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
              count <= count + ADDR_BITS'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= act;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            count     <= '0;
            acc       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
